lcd_init_arbiter: RTL

- Sequences the ST7735 LCD SPI interface. After reset it runs a fixed power-up/init script (hardware reset pulse, commands, data, delays) into the SPI interface's write port.
- After the script completes, it passes CPU iomem writes for the LCD window (iomem_addr[31:24]==8'h06) through to the same port, one at a time, gated on wbusy.
- Sits between the picosoc iomem decode and SPI_interface and replaces the direct wiring of both.

---
 rtl/lcd_init_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/lcd_init_arbiter.sv
// ST7735 power-up script sequencer that then arbitrates CPU iomem writes onto the SPI_interface write port.
// CPU reads ack the next cycle; CPU writes stall until the script is done and spi_wbusy is low, then ack after busy falls.
module lcd_init_arbiter #(
  parameter int CLKS_PER_MS = 12000,
  parameter bit AUTO_START  = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        cpu_valid,
  output logic        cpu_ready,
  input  logic [3:0]  cpu_wstrb,
  input  logic [7:0]  cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        spi_wstrb,
  output logic        spi_sel_cntl,
  output logic        spi_sel_cmd,
  output logic        spi_sel_dat,
  output logic        spi_sel_dat16,
  output logic [31:0] spi_wdata,
  input  logic        spi_wbusy,
  output logic        init_done
);

  typedef enum logic [1:0] {T_CNTL, T_CMD, T_DAT, T_DLY} entry_type_t;
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, GUARD, WAITBSY, DELAY, DONE} state_t;

  localparam logic [31:0] MS_CLKS = 32'(CLKS_PER_MS);

  state_t      state;
  logic [3:0]  ptr;
  logic [31:0] dly_cnt;
  logic [3:0]  iss_sel;   // {dat16, dat, cmd, cntl}
  logic [31:0] iss_dat;
  logic        cpu_wr;    // the transfer in flight belongs to the CPU

  entry_type_t rom_type;
  logic [7:0]  rom_pay;

  // Script entries; anything past the END marker also reads as END.
  always_comb begin
    rom_type = T_DLY;
    rom_pay  = 8'd0;
    case (ptr)
      4'd0:  begin rom_type = T_CNTL; rom_pay = 8'h00; end
      4'd1:  begin rom_type = T_DLY;  rom_pay = 8'd10;  end
      4'd2:  begin rom_type = T_CNTL; rom_pay = 8'h01; end
      4'd3:  begin rom_type = T_DLY;  rom_pay = 8'd120; end
      4'd4:  begin rom_type = T_CMD;  rom_pay = 8'h01; end
      4'd5:  begin rom_type = T_DLY;  rom_pay = 8'd150; end
      4'd6:  begin rom_type = T_CMD;  rom_pay = 8'h11; end
      4'd7:  begin rom_type = T_DLY;  rom_pay = 8'd120; end
      4'd8:  begin rom_type = T_CMD;  rom_pay = 8'h3A; end
      4'd9:  begin rom_type = T_DAT;  rom_pay = 8'h05; end
      4'd10: begin rom_type = T_CMD;  rom_pay = 8'h29; end
      default: begin rom_type = T_DLY; rom_pay = 8'd0; end
    endcase
  end

  // A request is fresh only when we are not already acknowledging it.
  logic cpu_req, cpu_rd, cpu_wr_req;
  assign cpu_req    = cpu_valid && !cpu_ready;
  assign cpu_rd     = cpu_req && (cpu_wstrb == 4'd0);
  assign cpu_wr_req = cpu_req && (cpu_wstrb != 4'd0);

  logic [3:0] cpu_sel;
  always_comb begin
    cpu_sel = 4'b0000;
    case (cpu_addr)
      8'h04:   cpu_sel = 4'b0001;
      8'h08:   cpu_sel = 4'b0010;
      8'h10:   cpu_sel = 4'b0100;
      8'h20:   cpu_sel = 4'b1000;
      default: cpu_sel = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      ptr           <= 4'd0;
      dly_cnt       <= 32'd0;
      iss_sel       <= 4'd0;
      iss_dat       <= 32'd0;
      cpu_wr        <= 1'b0;
      cpu_ready     <= 1'b0;
      cpu_rdata     <= 32'd0;
      spi_wstrb     <= 1'b0;
      spi_sel_cntl  <= 1'b0;
      spi_sel_cmd   <= 1'b0;
      spi_sel_dat   <= 1'b0;
      spi_sel_dat16 <= 1'b0;
      spi_wdata     <= 32'd0;
      init_done     <= 1'b0;
    end else begin
      spi_wstrb <= 1'b0;
      cpu_ready <= 1'b0;

      if (cpu_rd) begin
        cpu_ready <= 1'b1;
        cpu_rdata <= {30'd0, spi_wbusy, init_done};
      end

      case (state)
        IDLE: begin
          if (AUTO_START || start) begin
            ptr   <= 4'd0;
            state <= FETCH;
          end
        end
        FETCH: begin
          if (rom_type == T_DLY) begin
            if (rom_pay == 8'd0) begin
              init_done <= 1'b1;
              state     <= DONE;
            end else begin
              dly_cnt <= {24'd0, rom_pay} * MS_CLKS - 32'd1;
              state   <= DELAY;
            end
          end else begin
            iss_sel <= 4'b0001 << rom_type;
            iss_dat <= {24'd0, rom_pay};
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (!spi_wbusy) begin
            spi_wstrb <= 1'b1;
            {spi_sel_dat16, spi_sel_dat, spi_sel_cmd, spi_sel_cntl} <= iss_sel;
            spi_wdata <= iss_dat;
            state     <= GUARD;
          end
        end
        GUARD: begin
          // busy lags the strobe by a cycle, so it is not trusted here
          {spi_sel_dat16, spi_sel_dat, spi_sel_cmd, spi_sel_cntl} <= 4'd0;
          state <= WAITBSY;
        end
        WAITBSY: begin
          if (!spi_wbusy) begin
            if (cpu_wr) begin
              cpu_wr    <= 1'b0;
              cpu_ready <= 1'b1;
              state     <= DONE;
            end else begin
              ptr   <= ptr + 4'd1;
              state <= FETCH;
            end
          end
        end
        DELAY: begin
          if (dly_cnt == 32'd0) begin
            ptr   <= ptr + 4'd1;
            state <= FETCH;
          end else begin
            dly_cnt <= dly_cnt - 32'd1;
          end
        end
        DONE: begin
          if (cpu_wr_req) begin
            if (cpu_sel != 4'd0) begin
              iss_sel <= cpu_sel;
              iss_dat <= cpu_wdata;
              cpu_wr  <= 1'b1;
              state   <= ISSUE;
            end else begin
              cpu_ready <= 1'b1;
            end
          end else if (start) begin
            init_done <= 1'b0;
            ptr       <= 4'd0;
            state     <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
